// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB result type and port map for the single-CDB arbiter.
// cdb_t mirrors the core's result record; only cdb_valid is interpreted here.
package cdb_arbiter_pkg;

  typedef struct packed {
    logic        cdb_valid;
    logic [4:0]  rob_idx;
    logic [4:0]  rd;
    logic [31:0] data;
  } cdb_t;

  localparam int CDB_PORTS    = 4;
  localparam int CDB_PORT_LSU = 0;
  localparam int CDB_PORT_ALU = 1;
  localparam int CDB_PORT_MUL = 2;
  localparam int CDB_PORT_DIV = 3;

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU-to-CDB result handshake: requests and results in, one-hot ack and broadcast out.
// master = functional-unit side, slave = arbiter side.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = CDB_PORTS
);

  logic [NUM_FU-1:0]         fu_req;
  cdb_t [NUM_FU-1:0]         fu_cdb;
  logic [NUM_FU-1:0]         fu_ack;
  cdb_t                      cdb_out;
  logic [$clog2(NUM_FU)-1:0] cdb_src;

  modport master (
    output fu_req,
    output fu_cdb,
    input  fu_ack,
    input  cdb_out,
    input  cdb_src
  );

  modport slave (
    input  fu_req,
    input  fu_cdb,
    output fu_ack,
    output cdb_out,
    output cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational search for the first set request at or after a pointer, wrapping.
// Returns the winner as one-hot and as an index, plus a found flag.
module cdb_arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         found
);

  logic [W:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N; k++) begin
      // Extra bit so ptr+k can exceed N-1 before the modulo fold.
      cand = {1'b0, ptr} + (W+1)'(k);
      if (cand >= (W+1)'(N)) cand = cand - (W+1)'(N);
      if (!found && req[cand[W-1:0]]) begin
        found               = 1'b1;
        idx                 = cand[W-1:0];
        onehot[cand[W-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Single-CDB arbiter: grants one FU per cycle (starved > priority port > round robin)
// and broadcasts the captured result one cycle later.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU     = CDB_PORTS,
  parameter int PRIO_PORT  = CDB_PORT_LSU,
  parameter int MAX_STARVE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  cdb_arbiter_if.slave  bus
);

  localparam int W  = $clog2(NUM_FU);
  localparam int SW = $clog2(MAX_STARVE + 1);

  logic [W-1:0]              rr_ptr;
  logic [NUM_FU-1:0][SW-1:0] starve;
  logic [NUM_FU-1:0]         starved_req;

  logic [NUM_FU-1:0] oh_s, oh_r;
  logic [W-1:0]      idx_s, idx_r;
  logic              found_s, found_r;

  logic [NUM_FU-1:0] ack;
  logic [W-1:0]      g;
  logic              grant_any;
  logic [W-1:0]      next_ptr;

  cdb_t              cdb_q;
  logic [W-1:0]      src_q;

  always_comb begin
    starved_req = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      starved_req[i] = bus.fu_req[i] && (i != PRIO_PORT) &&
                       (starve[i] >= SW'(MAX_STARVE));
    end
  end

  cdb_arbiter_rr_pick #(.N(NUM_FU), .W(W)) u_rr_pick_starved (
    .req    (starved_req),
    .ptr    (rr_ptr),
    .onehot (oh_s),
    .idx    (idx_s),
    .found  (found_s)
  );

  cdb_arbiter_rr_pick #(.N(NUM_FU), .W(W)) u_rr_pick_plain (
    .req    (bus.fu_req),
    .ptr    (rr_ptr),
    .onehot (oh_r),
    .idx    (idx_r),
    .found  (found_r)
  );

  // Grant never looks at fu_cdb: the FU only drives its result once acked.
  always_comb begin
    ack       = '0;
    g         = '0;
    grant_any = 1'b0;
    if (rst && !flush) begin
      if (found_s) begin
        ack       = oh_s;
        g         = idx_s;
        grant_any = 1'b1;
      end else if (bus.fu_req[PRIO_PORT]) begin
        ack[PRIO_PORT] = 1'b1;
        g              = W'(PRIO_PORT);
        grant_any      = 1'b1;
      end else if (found_r) begin
        ack       = oh_r;
        g         = idx_r;
        grant_any = 1'b1;
      end
    end
  end

  assign next_ptr = (g == W'(NUM_FU - 1)) ? '0 : g + W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_q  <= '0;
      src_q  <= '0;
      rr_ptr <= '0;
      starve <= '0;
    end else begin
      if (grant_any) begin
        cdb_q <= bus.fu_cdb[g].cdb_valid ? bus.fu_cdb[g] : '0;
        src_q <= g;
        if (g != W'(PRIO_PORT)) rr_ptr <= next_ptr;
      end else begin
        cdb_q <= '0;
      end

      for (int i = 0; i < NUM_FU; i++) begin
        if (flush || (i == PRIO_PORT) || !bus.fu_req[i] || ack[i]) begin
          starve[i] <= '0;
        end else if (starve[i] < SW'(MAX_STARVE)) begin
          starve[i] <= starve[i] + SW'(1);
        end
      end
    end
  end

  assign bus.fu_ack  = ack;
  assign bus.cdb_out = cdb_q;
  assign bus.cdb_src = src_q;

  a_ack_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(ack));

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Single-CDB arbiter: the receiving end of the functional-unit result handshake (`cdb_alu_ack` / `cdb_output`).
- Grants one FU per cycle, captures the granted FU's `cdb_t`, and broadcasts it one cycle later to ROB, reservation stations and the register file.
- Round-robin among requesters, with one fixed-priority port (load/store) bounded by a per-port starvation cap.

Parameters:
- NUM_FU, 4, number of functional units on the CDB (≥2).
- PRIO_PORT, 0, index of the fixed-priority FU.
- MAX_STARVE, 3, consecutive denied cycles after which a non-priority requester overrides PRIO_PORT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  mispredict flush; kills capture and broadcast.
- fu_req  in  NUM_FU  FU has a finished result latched; registered in the FU, independent of fu_ack.
- fu_cdb  in  NUM_FU x $bits(cdb_t)  per-FU cdb_t, combinationally valid in the cycle its ack is high.
- fu_ack  out  NUM_FU  one-hot grant (FU side: `cdb_alu_ack`).
- cdb_out  out  $bits(cdb_t)  registered broadcast.
- cdb_src  out  $clog2(NUM_FU)  FU index that produced cdb_out.

Behaviour:
- Reset (rst=0, async):
  - cdb_out all zero (`cdb_valid=0`); cdb_src=0; fu_ack=0.
  - rr_ptr=0; all starve counters=0.
  - Reset mid-transfer drops the captured result.
- Grant, combinational from fu_req, rr_ptr, starve counters and flush only:
  - Must never depend on fu_cdb, because FU output depends on ack.
  - flush=1 → fu_ack=0.
  - Otherwise, if any non-priority port i has fu_req[i] and starve[i]≥MAX_STARVE, grant the lowest such i at or after rr_ptr, wrapping.
  - Else if fu_req[PRIO_PORT], grant PRIO_PORT.
  - Else grant the first requesting port at or after rr_ptr, wrapping modulo NUM_FU.
  - No requests → fu_ack=0.
  - fu_ack is one-hot or zero every cycle (assertion).
- Capture, at the posedge ending grant cycle N:
  - cdb_out ← fu_cdb[g]; cdb_src ← g. cdb_out is valid in cycle N+1 (1-cycle latency).
  - If fu_cdb[g].cdb_valid=0, the broadcast is a bubble: cdb_out zeroed.
  - No grant or flush=1 → cdb_out zeroed, `cdb_valid=0`.
- cdb_out is held exactly one cycle; there is no downstream backpressure.
- Pointer:
  - After a non-priority grant g, rr_ptr ← (g+1) mod NUM_FU.
  - A PRIO_PORT grant leaves rr_ptr unchanged.
  - Wrap from NUM_FU-1 goes to 0.
- Starve counters (non-priority ports only):
  - Requesting and not granted → increment, saturating at MAX_STARVE.
  - Granted or not requesting → cleared.
  - Flush → all cleared.
- Simultaneous events:
  - flush during a grant cycle: the ack is suppressed, so the FU keeps fu_req and re-requests after the flush.
  - flush in the cycle cdb_out is valid: no effect on that broadcast; ROB filters by rob index.
- Throughput: one result per cycle; back-to-back grants to the same FU are allowed when it is the only requester.

Decomposition:
- rv32i_types gains:
  - localparam CDB_PORTS.
  - Port-index constants: CDB_PORT_LSU=0, CDB_PORT_ALU=1, CDB_PORT_MUL=2, CDB_PORT_DIV=3.
  - cdb_t reused unchanged.
- One sub-module, rr_pick: pure combinational first-set-at-or-after-pointer search (request vector, pointer → one-hot, index, found).
  - Instantiated twice: starved-request vector and plain request vector.

Test Plan:
- Reset: rst=0 with fu_req=4'b1111 → fu_ack=0 and cdb_out.cdb_valid=0 while rst is low; first grant after release goes to port 0 (PRIO_PORT).
- Round robin without priority: fu_req=4'b1110 held, each FU returns `cdb_valid=1` and `data`=0x10+i → grants 1,2,3,1,…; cdb_out.data 0x11,0x12,0x13 on the following cycles; cdb_src matches.
- Priority and starvation: fu_req=4'b0011 held → port 0 granted 3 cycles, port 1 granted on the 4th (starve=3), then port 0 again.
- Bubble: port 2 alone requests but drives `cdb_valid=0` → fu_ack=4'b0100, next cycle cdb_out all zero; rr_ptr advances to 3.
- Flush: fu_req=4'b0100, flush=1 for one cycle → fu_ack=0, cdb_out invalid next cycle; port 2 granted the cycle after flush drops, data appears one cycle later.
- Async reset mid-transfer: rst falls between posedges right after a capture → cdb_out clears immediately, without waiting for a clock edge.
